// File: rtl/spiking_neuron_n.sv
// spiking_neuron_n: addressable integrate-and-fire neuron with leak and refractory period.
// A bus command (addr/cmd/cmd_arg) writes weights, threshold or leak, or clears the potential.
// Optional build macro SPIKING_NEURON_SATURATE_EN: clamp the stored potential instead of
// letting it wrap to FLOAT_WIDTH bits.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_INTEG  | integrating: leak-decay potential, add weighted spikes, fire
// ST_REFR   | refractory: inputs ignored, potential held at 0, timer runs
module spiking_neuron_n #(
    parameter int NEURON_ID   = 1,
    parameter int N_INPUTS    = 4,
    parameter int INT_WIDTH   = 4,
    parameter int CMD_WIDTH   = INT_WIDTH,
    parameter int ADDR_WIDTH  = INT_WIDTH,
    parameter int THRESHOLD   = 8,
    parameter int REFRACTORY  = 2,
    localparam int FLOAT_WIDTH = 2 * INT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         addr,
    input  logic [CMD_WIDTH-1:0]          cmd,
    input  logic signed [FLOAT_WIDTH-1:0] cmd_arg,
    input  logic [N_INPUTS-1:0]           in,
    output logic                          out
);

    localparam int FW    = FLOAT_WIDTH;
    localparam int SUM_W = FW + $clog2(N_INPUTS) + 1;
    localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

    localparam logic [CMD_WIDTH-1:0] CMD_ALL1 = '1;
    localparam logic [CMD_WIDTH-1:0] CMD_THR  = CMD_ALL1 - CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] CMD_CLR  = CMD_ALL1 - CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] CMD_LEAK = CMD_ALL1 - CMD_WIDTH'(3);

    typedef enum logic [0:0] {
        ST_INTEG = 1'b0,
        ST_REFR  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [FW-1:0] weight [N_INPUTS];
    logic signed [FW-1:0] threshold;
    logic        [FW-1:0] leak;
    logic signed [FW-1:0] potential;
    logic [REF_W-1:0]     refr_cnt;

    logic                 sel;
    logic                 clr;
    logic signed [FW:0]   pot_ext;
    logic signed [FW:0]   leak_ext;
    logic signed [FW:0]   diff;
    logic signed [FW-1:0] decayed;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] thr_ext;
    logic                 fire;
    logic signed [FW-1:0] pot_store;

    logic signed [FW-1:0] pot_nxt;
    logic [REF_W-1:0]     cnt_nxt;
    logic                 out_nxt;

    assign sel = (addr == ADDR_WIDTH'(NEURON_ID));
    assign clr = sel && (cmd == CMD_CLR);

    // Leak decay: pull the potential toward zero by leak without crossing zero.
    always_comb begin
        pot_ext  = {potential[FW-1], potential};
        leak_ext = {1'b0, leak};
        diff     = '0;
        decayed  = '0;
        if (potential[FW-1]) begin
            diff = pot_ext + leak_ext;
            if (diff[FW]) decayed = diff[FW-1:0];
        end else if (potential != '0) begin
            diff = pot_ext - leak_ext;
            if (!diff[FW]) decayed = diff[FW-1:0];
        end
    end

    // Integrate decayed potential plus active weights at full width, then compare.
    always_comb begin
        sum = {{(SUM_W-FW){decayed[FW-1]}}, decayed};
        for (int i = 0; i < N_INPUTS; i++) begin
            if (in[i]) sum = sum + {{(SUM_W-FW){weight[i][FW-1]}}, weight[i]};
        end
        thr_ext = {{(SUM_W-FW){threshold[FW-1]}}, threshold};
        fire    = (sum >= thr_ext);
    end

`ifdef SPIKING_NEURON_SATURATE_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-FW+1){1'b0}}, {(FW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-FW+1){1'b1}}, {(FW-1){1'b0}}};

    // Clamp the sum into the potential's signed range.
    always_comb begin
        if (sum > SAT_MAX)      pot_store = SAT_MAX[FW-1:0];
        else if (sum < SAT_MIN) pot_store = SAT_MIN[FW-1:0];
        else                    pot_store = sum[FW-1:0];
    end
`else
    // Two's-complement wrap of the sum into the potential.
    always_comb begin
        pot_store = sum[FW-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INTEG;
        else      state <= state_nxt;
    end

    // Next-state logic: CLEAR always returns to integration; refractory ends at terminal count.
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = ST_INTEG;
        end else begin
            case (state)
                ST_INTEG: if (fire && (REFRACTORY > 0)) state_nxt = ST_REFR;
                ST_REFR:  if (refr_cnt <= REF_W'(1))    state_nxt = ST_INTEG;
                default:  state_nxt = ST_INTEG;
            endcase
        end
    end

    // Output/datapath next values for each state; CLEAR overrides firing.
    always_comb begin
        pot_nxt = potential;
        cnt_nxt = refr_cnt;
        out_nxt = 1'b0;
        if (clr) begin
            pot_nxt = '0;
            cnt_nxt = '0;
        end else begin
            case (state)
                ST_INTEG: begin
                    if (fire) begin
                        pot_nxt = '0;
                        cnt_nxt = REF_W'(REFRACTORY);
                        out_nxt = 1'b1;
                    end else begin
                        pot_nxt = pot_store;
                    end
                end
                ST_REFR: begin
                    pot_nxt = '0;
                    if (refr_cnt != '0) cnt_nxt = refr_cnt - REF_W'(1);
                end
                default: begin
                    pot_nxt = '0;
                    cnt_nxt = '0;
                end
            endcase
        end
    end

    // Neuron state and configuration registers; writes land after the current integration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            potential <= '0;
            refr_cnt  <= '0;
            out       <= 1'b0;
            threshold <= FW'(THRESHOLD);
            leak      <= '0;
            for (int i = 0; i < N_INPUTS; i++) weight[i] <= '0;
        end else begin
            potential <= pot_nxt;
            refr_cnt  <= cnt_nxt;
            out       <= out_nxt;
            if (sel) begin
                for (int i = 0; i < N_INPUTS; i++) begin
                    if (cmd == CMD_WIDTH'(i + 1)) weight[i] <= cmd_arg;
                end
                if (cmd == CMD_THR)  threshold <= cmd_arg;
                if (cmd == CMD_LEAK) leak      <= cmd_arg[FW-1] ? '0 : cmd_arg;
            end
        end
    end

endmodule

// File: tb/tb_spiking_neuron_n.sv
// Bench for spiking_neuron_n (default parameters): directed scenarios followed by random
// bus/spike traffic, all compared against an integer reference model of the neuron rules.
module tb_spiking_neuron_n;

    localparam int REFR  = 2;
    localparam int THR0  = 8;
    localparam logic [3:0] IDLE_A = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        addr;
    logic [3:0]        cmd;
    logic signed [7:0] cmd_arg;
    logic [3:0]        in_s;
    logic              out_s;

    int errors = 0;
    int checks = 0;

    int m_pot, m_refr, m_thr, m_leak, m_out;
    int m_w[4];

    spiking_neuron_n #(
        .NEURON_ID(1), .N_INPUTS(4), .INT_WIDTH(4), .CMD_WIDTH(4), .ADDR_WIDTH(4),
        .THRESHOLD(THR0), .REFRACTORY(REFR)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .cmd(cmd), .cmd_arg(cmd_arg),
        .in(in_s), .out(out_s)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_pot = 0; m_refr = 0; m_thr = THR0; m_leak = 0; m_out = 0;
        for (int i = 0; i < 4; i++) m_w[i] = 0;
    endfunction

    function automatic int wrap8(int s);
        int t;
        t = s & 255;
        return (t >= 128) ? t - 256 : t;
    endfunction

    function automatic int store8(int s);
`ifdef SPIKING_NEURON_SATURATE_EN
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
`else
        return wrap8(s);
`endif
    endfunction

    // One rising edge of the neuron, written from the behavioural rules.
    function automatic void model_edge(logic [3:0] a, logic [3:0] c, int arg, logic [3:0] inb);
        bit sel;
        int d, s, ci;
        sel = (a == 4'd1);
        ci  = int'(c);
        if (sel && ci == 13) begin
            m_pot = 0; m_refr = 0; m_out = 0;
        end else if (m_refr > 0) begin
            m_refr = m_refr - 1; m_pot = 0; m_out = 0;
        end else begin
            if (m_pot > 0)      d = (m_pot > m_leak) ? m_pot - m_leak : 0;
            else if (m_pot < 0) d = (-m_pot > m_leak) ? m_pot + m_leak : 0;
            else                d = 0;
            s = d;
            for (int i = 0; i < 4; i++) if (inb[i]) s += m_w[i];
            if (s >= m_thr) begin
                m_out = 1; m_pot = 0; m_refr = REFR;
            end else begin
                m_out = 0; m_pot = store8(s);
            end
        end
        if (sel) begin
            if (ci >= 1 && ci <= 4) m_w[ci-1] = arg;
            else if (ci == 14)      m_thr = arg;
            else if (ci == 12)      m_leak = (arg < 0) ? 0 : arg;
        end
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic [3:0] a, input logic [3:0] c, input logic signed [7:0] arg,
                         input logic [3:0] inb, input string tag);
        @(negedge clk);
        addr = a; cmd = c; cmd_arg = arg; in_s = inb;
        @(posedge clk);
        model_edge(a, c, int'(arg), inb);
        #1;
        chk({tag, ".out"}, out_s, m_out);
        chk({tag, ".pot"}, dut.potential, m_pot);
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(IDLE_A, 4'd0, 8'sd0, 4'b0000, tag);
    endtask

    initial begin
        logic [3:0] ra;
        rst = 1'b0; addr = IDLE_A; cmd = '0; cmd_arg = '0; in_s = '0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", out_s, 0);
        chk("reset.pot", dut.potential, 0);
        chk("reset.refr", dut.refr_cnt, 0);
        @(negedge clk) rst = 1'b1;

        // two-step accumulation to threshold
        cycle(4'd1, 4'd1, 8'sd7, 4'b0000, "wr_w0");
        cycle(4'd1, 4'd2, 8'sd7, 4'b0000, "wr_w1");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "acc_k");
        chk("acc_k.pot7", dut.potential, 7);
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0010, "acc_k1");
        chk("acc_k1.fire", out_s, 1);
        idle(1, "acc_after");
        chk("acc_after.low", out_s, 0);
        idle(2, "acc_refr");

        // coincident inputs fire in one edge
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0011, "coinc");
        chk("coinc.fire", out_s, 1);
        idle(3, "coinc_after");

        // held input: pulses every REFR+1 cycles; reset lands mid-refractory
        cycle(4'd1, 4'd1, 8'sd8, 4'b0000, "wr_w0_8");
        for (int k = 0; k < 7; k++) cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "held");
        chk("held.last_fire", out_s, 1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mid.out", out_s, 0);
        chk("rst_mid.pot", dut.potential, 0);
        chk("rst_mid.refr", dut.refr_cnt, 0);
        chk("rst_mid.w0", dut.weight[0], 0);
        @(negedge clk) rst = 1'b1;
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "post_rst");

        // leak decay
        cycle(4'd1, 4'd12, 8'sd2, 4'b0000, "wr_leak2");
        cycle(4'd1, 4'd1, 8'sd5, 4'b0000, "wr_w0_5");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "leak_pulse");
        idle(4, "leak_decay");
        chk("leak_decay.zero", dut.potential, 0);

        // negative leak argument stores zero leak
        cycle(4'd1, 4'd12, -8'sd3, 4'b0000, "wr_leak_neg");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "noleak_pulse");
        idle(2, "noleak_hold");
        chk("noleak_hold.pot5", dut.potential, 5);
        cycle(4'd1, 4'd13, 8'sd0, 4'b0000, "clear");

        // large negative sums: wrap vs saturate
        for (int i = 0; i < 4; i++) cycle(4'd1, 4'(i + 1), -8'sd128, 4'b0000, "wr_wneg");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b1111, "neg_sum1");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b1111, "neg_sum2");
`ifdef SPIKING_NEURON_SATURATE_EN
        chk("neg_sum.value", dut.potential, -128);
`else
        chk("neg_sum.value", dut.potential, 0);
`endif
        cycle(4'd1, 4'd13, 8'sd0, 4'b0000, "clear2");

        // write coincident with integration uses the old threshold
        cycle(4'd1, 4'd1, 8'sd7, 4'b0000, "wr_w0_7");
        cycle(4'd1, 4'd2, 8'sd7, 4'b0000, "wr_w1_7");
        cycle(4'd1, 4'd14, 8'sd3, 4'b0001, "thr_same");
        chk("thr_same.nofire", out_s, 0);
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0000, "thr_new");
        chk("thr_new.fire", out_s, 1);
        idle(2, "thr_refr");

        // writes to another address are ignored
        cycle(4'd2, 4'd14, 8'sd100, 4'b0000, "foreign_thr");
        cycle(4'd2, 4'd1, -8'sd50, 4'b0000, "foreign_w0");
        cycle(4'd2, 4'd13, 8'sd0, 4'b0001, "foreign_clr");
        chk("foreign.fire", out_s, 1);
        idle(2, "foreign_refr");

        // CLEAR beats firing, and leaves no refractory period
        cycle(4'd1, 4'd14, 8'sd8, 4'b0000, "wr_thr8");
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0001, "pre_clr");
        cycle(4'd1, 4'd13, 8'sd0, 4'b0010, "clr_fire");
        chk("clr_fire.out", out_s, 0);
        cycle(IDLE_A, 4'd0, 8'sd0, 4'b0011, "after_clr");
        chk("after_clr.fire", out_s, 1);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = 4'd1;
                2:       ra = 4'd2;
                default: ra = IDLE_A;
            endcase
            cycle(ra, 4'($urandom_range(0, 15)), 8'($urandom), 4'($urandom), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
